// File: rtl/afifo_burst_reader_if.sv
// Command, afifo read-port and output-stream signals of the burst reader.
// The slave modport is the reader's own view; the master modport is the surrounding logic.
interface afifo_burst_reader_if #(
   parameter int AW = 20,
   parameter int DW = 128,
   parameter int LW = 8
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [LW-1:0] cmd_len;
   logic          fifo_re;
   logic          fifo_rempty;
   logic [AW:0]   fifo_rcnt;
   logic [DW-1:0] fifo_q;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          busy;

   modport master (
      output cmd_valid, cmd_len, fifo_rempty, fifo_rcnt, fifo_q, m_ready,
      input  cmd_ready, fifo_re, m_valid, m_data, m_last, busy
   );

   modport slave (
      input  cmd_valid, cmd_len, fifo_rempty, fifo_rcnt, fifo_q, m_ready,
      output cmd_ready, fifo_re, m_valid, m_data, m_last, busy
   );
endinterface

// File: rtl/afifo_burst_reader.sv
// Drains a show-ahead afifo read port into valid/ready bursts with a last flag.
// WHOLE=1 holds off popping until the FIFO occupancy covers the whole burst.
module afifo_burst_reader #(
   parameter int AW    = 20,
   parameter int DW    = 128,
   parameter int LW    = 8,
   parameter int WHOLE = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   afifo_burst_reader_if.slave  bus
);

   localparam int CW = ((AW > LW) ? AW : LW) + 1;
   localparam logic [CW-1:0] DEPTH = CW'(1) << AW;

   typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

   state_t        state;
   logic [LW-1:0] rem;
   logic          valid_r;
   logic          last_r;
   logic [DW-1:0] data_r;

   logic          load;
   logic          pop;
   logic [CW-1:0] rcnt_ext;
   logic [CW-1:0] need_ext;

   // The output register may take a new beat when it is empty or being drained this cycle
   assign load     = ~valid_r | bus.m_ready;
   assign pop      = (state == XFER) & load & ~bus.fifo_rempty;
   assign rcnt_ext = CW'(bus.fifo_rcnt);
   assign need_ext = CW'(rem) + CW'(1);

   assign bus.cmd_ready = (state == IDLE);
   assign bus.fifo_re   = pop;
   assign bus.m_valid   = valid_r;
   assign bus.m_data    = data_r;
   assign bus.m_last    = last_r;
   assign bus.busy      = (state != IDLE) | valid_r;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         rem     <= '0;
         valid_r <= 1'b0;
         last_r  <= 1'b0;
         data_r  <= '0;
      end else begin
         if (pop) begin
            data_r  <= bus.fifo_q;
            valid_r <= 1'b1;
            last_r  <= (rem == '0);
         end else if (valid_r && bus.m_ready) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  rem   <= bus.cmd_len;
                  state <= (WHOLE != 0) ? WAIT : XFER;
               end
            end
            WAIT: begin
               if (rcnt_ext >= need_ext) begin
                  state <= XFER;
               end
            end
            XFER: begin
               // rem is held at zero on the final pop so it never wraps
               if (pop) begin
                  if (rem == '0) begin
                     state <= IDLE;
                  end else begin
                     rem <= rem - 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A burst longer than the FIFO depth would sit in WAIT forever
   a_burst_fits: assert property (@(posedge clk) disable iff (!reset_n)
      (state == WAIT) |-> (need_ext <= DEPTH));

endmodule

// File: tb/tb_afifo_burst_reader.sv
// Directed bench for afifo_burst_reader: one WHOLE=1/AW=4 instance and one WHOLE=0/AW=8
// instance, each fed by a small show-ahead FIFO model.
module tb_afifo_burst_reader;

   logic clk;
   logic reset_a;
   logic reset_b;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   afifo_burst_reader_if #(.AW(4), .DW(16), .LW(8)) if_a ();
   afifo_burst_reader_if #(.AW(8), .DW(16), .LW(8)) if_b ();

   afifo_burst_reader #(.AW(4), .DW(16), .LW(8), .WHOLE(1)) dut_a (
      .clk     (clk),
      .reset_n (reset_a),
      .bus     (if_a)
   );

   afifo_burst_reader #(.AW(8), .DW(16), .LW(8), .WHOLE(0)) dut_b (
      .clk     (clk),
      .reset_n (reset_b),
      .bus     (if_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO models: contents survive a reader reset, pointers move on the clock edge
   logic [15:0] mem_a [0:255];
   logic [15:0] mem_b [0:255];
   logic [8:0]  wp_a = '0, rp_a = '0, wp_b = '0, rp_b = '0;
   logic        push_a, push_b;
   logic [15:0] push_data_a, push_data_b;
   int          pops_a = 0, pops_b = 0, empty_pop_a = 0, empty_pop_b = 0;

   assign if_a.fifo_rempty = (wp_a == rp_a);
   assign if_a.fifo_rcnt   = 5'(wp_a - rp_a);
   assign if_a.fifo_q      = mem_a[rp_a[7:0]];
   assign if_b.fifo_rempty = (wp_b == rp_b);
   assign if_b.fifo_rcnt   = 9'(wp_b - rp_b);
   assign if_b.fifo_q      = mem_b[rp_b[7:0]];

   always @(posedge clk) begin
      if (if_a.fifo_re) begin
         rp_a   <= rp_a + 9'd1;
         pops_a <= pops_a + 1;
         if (if_a.fifo_rempty) empty_pop_a <= empty_pop_a + 1;
      end
      if (push_a) begin
         mem_a[wp_a[7:0]] <= push_data_a;
         wp_a             <= wp_a + 9'd1;
      end
      if (if_b.fifo_re) begin
         rp_b   <= rp_b + 9'd1;
         pops_b <= pops_b + 1;
         if (if_b.fifo_rempty) empty_pop_b <= empty_pop_b + 1;
      end
      if (push_b) begin
         mem_b[wp_b[7:0]] <= push_data_b;
         wp_b             <= wp_b + 9'd1;
      end
   end

   // Accepted-beat collectors and a stall-stability monitor on instance A
   logic [15:0] dq_a[$], dq_b[$];
   bit          lq_a[$], lq_b[$];
   int          cq_a[$], cq_b[$];
   bit          stall_a = 1'b0;
   logic [15:0] hold_a;
   int          unstable_a = 0;

   always @(posedge clk) begin
      if (reset_a && if_a.m_valid && if_a.m_ready) begin
         dq_a.push_back(if_a.m_data);
         lq_a.push_back(if_a.m_last);
         cq_a.push_back(cyc);
      end
      if (reset_b && if_b.m_valid && if_b.m_ready) begin
         dq_b.push_back(if_b.m_data);
         lq_b.push_back(if_b.m_last);
         cq_b.push_back(cyc);
      end
      if (stall_a && if_a.m_data !== hold_a) unstable_a++;
      stall_a = if_a.m_valid & ~if_a.m_ready;
      hold_a  = if_a.m_data;
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_word_a(input logic [15:0] d);
      push_a      = 1'b1;
      push_data_a = d;
      @(negedge clk);
      push_a      = 1'b0;
   endtask

   task automatic push_word_b(input logic [15:0] d);
      push_b      = 1'b1;
      push_data_b = d;
      @(negedge clk);
      push_b      = 1'b0;
   endtask

   task automatic apply_cmd_a(input logic [7:0] len);
      if_a.cmd_len   = len;
      if_a.cmd_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (if_a.cmd_ready) break;
         @(negedge clk);
      end
      check_output("cmd_accept_a", 32'(if_a.cmd_ready), 32'd1);
      @(negedge clk);
      if_a.cmd_valid = 1'b0;
   endtask

   task automatic apply_cmd_b(input logic [7:0] len);
      if_b.cmd_len   = len;
      if_b.cmd_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (if_b.cmd_ready) break;
         @(negedge clk);
      end
      check_output("cmd_accept_b", 32'(if_b.cmd_ready), 32'd1);
      @(negedge clk);
      if_b.cmd_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          base;
      int          ubase;
      int          bad;
      int          nlast;
      logic [7:0]  lv;

      reset_a = 1'b0;  reset_b = 1'b0;
      push_a = 1'b0;   push_b = 1'b0;
      push_data_a = '0; push_data_b = '0;
      if_a.cmd_valid = 1'b0; if_a.cmd_len = '0; if_a.m_ready = 1'b1;
      if_b.cmd_valid = 1'b0; if_b.cmd_len = '0; if_b.m_ready = 1'b1;
      #1;
      check_output("rst_cmd_ready", 32'(if_a.cmd_ready), 32'd1);
      check_output("rst_fifo_re",   32'(if_a.fifo_re),   32'd0);
      check_output("rst_busy",      32'(if_a.busy),      32'd0);
      check_output("rst_m_valid",   32'(if_a.m_valid),   32'd0);
      check_output("rst_m_last",    32'(if_a.m_last),    32'd0);
      check_output("rst_m_data",    32'(if_a.m_data),    32'd0);
      check_output("rst_b_ready",   32'(if_b.cmd_ready), 32'd1);
      @(negedge clk);
      reset_a = 1'b1; reset_b = 1'b1;
      @(negedge clk);

      // Whole-burst wait: 2 of 4 entries present must not start the burst
      push_word_a(16'hD000);
      push_word_a(16'hD001);
      base = pops_a;
      dq_a.delete(); lq_a.delete(); cq_a.delete();
      apply_cmd_a(8'd3);
      repeat (6) @(negedge clk);
      check_output("t1_wait_pops",      32'(pops_a - base),   32'd0);
      check_output("t1_wait_fifo_re",   32'(if_a.fifo_re),    32'd0);
      check_output("t1_wait_cmd_ready", 32'(if_a.cmd_ready),  32'd0);
      check_output("t1_wait_busy",      32'(if_a.busy),       32'd1);
      push_word_a(16'hD002);
      push_word_a(16'hD003);
      for (int i = 0; i < 20 && dq_a.size() < 4; i++) @(negedge clk);
      check_output("t1_count", 32'(dq_a.size()), 32'd4);
      for (int k = 0; k < 4; k++)
         check_output($sformatf("t1_data%0d", k), 32'(dq_a[k]), 32'(16'hD000 + k));
      lv = '0;
      for (int k = 0; k < dq_a.size() && k < 8; k++) lv[k] = lq_a[k];
      check_output("t1_last",       32'(lv),                 32'h08);
      check_output("t1_span",       32'(cq_a[3] - cq_a[0]),  32'd3);
      check_output("t1_pops",       32'(pops_a - base),      32'd4);
      check_output("t1_cmd_ready",  32'(if_a.cmd_ready),     32'd1);
      check_output("t1_busy",       32'(if_a.busy),          32'd0);

      // Streaming with a slow producer: one entry every 3 cycles
      base = pops_b;
      dq_b.delete(); lq_b.delete(); cq_b.delete();
      apply_cmd_b(8'd7);
      for (int k = 0; k < 8; k++) begin
         push_word_b(16'h3000 + 16'(k));
         repeat (2) @(negedge clk);
      end
      for (int i = 0; i < 20 && dq_b.size() < 8; i++) @(negedge clk);
      check_output("t2_count", 32'(dq_b.size()), 32'd8);
      for (int k = 0; k < 8; k++)
         check_output($sformatf("t2_data%0d", k), 32'(dq_b[k]), 32'(16'h3000 + k));
      lv = '0;
      for (int k = 0; k < dq_b.size() && k < 8; k++) lv[k] = lq_b[k];
      check_output("t2_last",        32'(lv),                 32'h80);
      check_output("t2_span",        32'(cq_b[7] - cq_b[0]),  32'd21);
      check_output("t2_pops",        32'(pops_b - base),      32'd8);
      check_output("t2_empty_pops",  32'(empty_pop_b),        32'd0);

      // Backpressure against a full FIFO, m_ready pattern 1,0,0,...
      for (int k = 0; k < 16; k++) push_word_a(16'h0100 + 16'(k));
      check_output("t3_full_rcnt", 32'(if_a.fifo_rcnt), 32'd16);
      base  = pops_a;
      ubase = unstable_a;
      dq_a.delete(); lq_a.delete(); cq_a.delete();
      apply_cmd_a(8'd4);
      for (int i = 0; i < 60 && dq_a.size() < 5; i++) begin
         if_a.m_ready = (i % 3 == 0);
         @(negedge clk);
      end
      if_a.m_ready = 1'b1;
      repeat (5) @(negedge clk);
      check_output("t3_count", 32'(dq_a.size()), 32'd5);
      for (int k = 0; k < 5; k++)
         check_output($sformatf("t3_data%0d", k), 32'(dq_a[k]), 32'(16'h0100 + k));
      lv = '0;
      for (int k = 0; k < dq_a.size() && k < 8; k++) lv[k] = lq_a[k];
      check_output("t3_last",        32'(lv),                  32'h10);
      check_output("t3_pops",        32'(pops_a - base),       32'd5);
      check_output("t3_stable",      32'(unstable_a - ubase),  32'd0);
      check_output("t3_rcnt_left",   32'(if_a.fifo_rcnt),      32'd11);
      check_output("t3_empty_pops",  32'(empty_pop_a),         32'd0);

      // Back-to-back commands len=0 then len=1
      push_word_b(16'h00A0);
      push_word_b(16'h00B0);
      push_word_b(16'h00C0);
      dq_b.delete(); lq_b.delete(); cq_b.delete();
      apply_cmd_b(8'd0);
      apply_cmd_b(8'd1);
      for (int i = 0; i < 20 && dq_b.size() < 3; i++) @(negedge clk);
      check_output("t4_count", 32'(dq_b.size()), 32'd3);
      check_output("t4_data0", 32'(dq_b[0]), 32'h00A0);
      check_output("t4_data1", 32'(dq_b[1]), 32'h00B0);
      check_output("t4_data2", 32'(dq_b[2]), 32'h00C0);
      lv = '0;
      for (int k = 0; k < dq_b.size() && k < 8; k++) lv[k] = lq_b[k];
      check_output("t4_last",   32'(lv),                 32'h05);
      check_output("t4_gap_ab", 32'(cq_b[1] - cq_b[0]),  32'd2);
      check_output("t4_gap_bc", 32'(cq_b[2] - cq_b[1]),  32'd1);

      // Reset while beat 2 of a 4-beat burst sits in the output register
      for (int k = 0; k < 4; k++) push_word_b(16'h0050 + 16'(k));
      base = pops_b;
      dq_b.delete(); lq_b.delete(); cq_b.delete();
      apply_cmd_b(8'd3);
      for (int i = 0; i < 20 && dq_b.size() < 1; i++) @(negedge clk);
      check_output("t5_pops_before", 32'(pops_b - base), 32'd2);
      check_output("t5_held_data",   32'(if_b.m_data),   32'h0051);
      reset_b = 1'b0;
      #1;
      check_output("t5_rst_m_valid",   32'(if_b.m_valid),   32'd0);
      check_output("t5_rst_m_last",    32'(if_b.m_last),    32'd0);
      check_output("t5_rst_cmd_ready", 32'(if_b.cmd_ready), 32'd1);
      check_output("t5_rst_busy",      32'(if_b.busy),      32'd0);
      @(negedge clk);
      reset_b = 1'b1;
      check_output("t5_fifo_kept", 32'(if_b.fifo_rcnt), 32'd2);
      dq_b.delete(); lq_b.delete(); cq_b.delete();
      apply_cmd_b(8'd1);
      for (int i = 0; i < 20 && dq_b.size() < 2; i++) @(negedge clk);
      check_output("t5_count", 32'(dq_b.size()), 32'd2);
      check_output("t5_data0", 32'(dq_b[0]), 32'h0052);
      check_output("t5_data1", 32'(dq_b[1]), 32'h0053);
      lv = '0;
      for (int k = 0; k < dq_b.size() && k < 8; k++) lv[k] = lq_b[k];
      check_output("t5_last",   32'(lv),               32'h02);
      check_output("t5_rempty", 32'(if_b.fifo_rempty), 32'd1);

      // Maximum length burst: cmd_len=255 gives 256 beats
      for (int k = 0; k < 256; k++) push_word_b(16'h2000 + 16'(k));
      check_output("t6_rcnt", 32'(if_b.fifo_rcnt), 32'd256);
      base = pops_b;
      dq_b.delete(); lq_b.delete(); cq_b.delete();
      apply_cmd_b(8'd255);
      for (int i = 0; i < 400 && dq_b.size() < 256; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check_output("t6_count", 32'(dq_b.size()), 32'd256);
      bad   = 0;
      nlast = 0;
      for (int k = 0; k < dq_b.size(); k++) begin
         if (dq_b[k] !== 16'h2000 + 16'(k)) bad++;
         if (lq_b[k]) nlast++;
      end
      check_output("t6_data_errs",  32'(bad),                 32'd0);
      check_output("t6_last_count", 32'(nlast),               32'd1);
      check_output("t6_last_final", 32'(lq_b[255]),           32'd1);
      check_output("t6_pops",       32'(pops_b - base),       32'd256);
      check_output("t6_cmd_ready",  32'(if_b.cmd_ready),      32'd1);
      check_output("t6_busy",       32'(if_b.busy),           32'd0);
      check_output("t6_rempty",     32'(if_b.fifo_rempty),    32'd1);
      check_output("t6_empty_pops", 32'(empty_pop_b),         32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
